// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that streams one nibble per clock through a 4-bit add stage.
// Optional signed-overflow output enabled by SERIAL_NIBBLE_ADDER_OVF_EN.
module serial_nibble_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IW   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             done_d;
  logic             busy_d;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
  logic             ovf_d;
`endif

  // Nibble slice selection and 4-bit add stage (A, B, cin -> Sum, co)
  logic [IW+1:0]    shamt;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] nib_mask;
  logic [WIDTH-1:0] merged;

  always_comb begin
    shamt    = {idx_q, 2'b00};
    nib_a    = 4'(a_q >> shamt);
    nib_b    = 4'(b_q >> shamt);
    nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    nib_mask = WIDTH'(4'hF) << shamt;
    merged   = (work_q & ~nib_mask) | (WIDTH'(nib_sum[3:0]) << shamt);
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum;
    cout_d  = cout;
    done_d  = 1'b0;
    busy_d  = busy;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    ovf_d   = ovf;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d  = merged;
        carry_d = nib_sum[4];
        if (idx_q == LAST) begin
          sum_d   = merged;
          cout_d  = nib_sum[4];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum     <= sum_d;
      cout    <= cout_d;
      done    <= done_d;
      busy    <= busy_d;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
      ovf     <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder: WIDTH=16 vector table and corner sequences,
// plus exhaustive WIDTH=4 sweep.
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
  logic        ovf16, ovf4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_nibble_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  serial_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Waits for done after the accept edge; also verifies busy stays high and sum holds.
  task automatic wait_done16(output int lat, output logic hold_ok);
    logic [15:0] prev;
    prev    = sum16;
    lat     = 1;
    hold_ok = busy16 && !done16;
    tick();
    while (!done16 && lat < 20) begin
      if (!busy16 || sum16 !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  int   lat;
  logic hold_ok;
  int   ndone;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

    rst = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("reset_busy", 32'(busy16), 32'd0);
    check("reset_done", 32'(done16), 32'd0);
    check("reset_sum",  32'(sum16),  32'd0);
    check("reset_cout", 32'(cout16), 32'd0);

    // Table of WIDTH=16 vectors
    for (int i = 0; i < 9; i++) begin
      a16 = vecs[i].a; b16 = vecs[i].b; cin16 = vecs[i].cin; start16 = 1'b1;
      tick();
      start16 = 1'b0; a16 = ~vecs[i].a; b16 = ~vecs[i].b; cin16 = ~vecs[i].cin;
      wait_done16(lat, hold_ok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_busy_hold", i), 32'(hold_ok), 32'd1);
      check($sformatf("v%0d_sum", i), 32'(sum16), 32'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 32'(cout16), 32'(vecs[i].cout));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy16), 32'd0);
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(ovf16), 32'(vecs[i].ovf));
`endif
      tick();
      check($sformatf("v%0d_done_single", i), 32'(done16), 32'd0);
      check($sformatf("v%0d_sum_kept", i), 32'(sum16), 32'(vecs[i].sum));
    end

    // Back-to-back: new start accepted in the done cycle
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    wait_done16(lat, hold_ok);
    check("b2b_first_sum", 32'(sum16), 32'h5556);
    a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("b2b_done_dropped", 32'(done16), 32'd0);
    check("b2b_busy", 32'(busy16), 32'd1);
    wait_done16(lat, hold_ok);
    check("b2b_latency", 32'(lat), 32'd4);
    check("b2b_second_sum", 32'(sum16), 32'h1000);
    check("b2b_second_cout", 32'(cout16), 32'd0);
    tick();

    // Start while busy is ignored
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    a16 = 16'hAAAA; b16 = 16'h5555; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done16) begin
        ndone++;
        check("ign_sum", 32'(sum16), 32'h0100);
        check("ign_cout", 32'(cout16), 32'd0);
      end
      tick();
    end
    check("ign_done_count", 32'(ndone), 32'd1);

    // Reset two cycles into an add
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", 32'(busy16), 32'd0);
    check("rst_mid_done", 32'(done16), 32'd0);
    check("rst_mid_sum",  32'(sum16),  32'd0);
    check("rst_mid_cout", 32'(cout16), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done16) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);

    // Exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      logic [4:0] expv;
      logic [3:0] ai, bi;
      logic       ci;
      ai = 4'(i >> 5); bi = 4'(i >> 1); ci = i[0];
      expv = {1'b0, ai} + {1'b0, bi} + {4'b0000, ci};
      a4 = ai; b4 = bi; cin4 = ci; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      if (done4 !== 1'b0 || busy4 !== 1'b1) begin
        tests++; fails++;
        $display("FAIL w4_accept a=%0h b=%0h cin=%0b: done=%0b busy=%0b expected done=0 busy=1",
                 ai, bi, ci, done4, busy4);
      end
      tick();
      check($sformatf("w4_done a=%0h b=%0h cin=%0b", ai, bi, ci), 32'(done4), 32'd1);
      check($sformatf("w4_result a=%0h b=%0h cin=%0b", ai, bi, ci), 32'({cout4, sum4}), 32'(expv));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
